// File: rtl/rr_mux_select_if.sv
// rr_mux_select_if: request/release handshake and mux-select bundle between
// the four requesters, the round-robin arbiter and the 4:1 channel mux.
//   master : requester side (drives req/done, observes the grant)
//   slave  : arbiter side (observes req/done, drives the grant)
interface rr_mux_select_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  sel,
    input  gnt,
    input  valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output sel,
    output gnt,
    output valid,
    output timeout
  );
endinterface

// File: rtl/rr_mux_select.sv
// rr_mux_select: round-robin arbiter for the 4:1 tri-state channel mux.
// Grants one of four requesters, holds the grant until released, and rotates
// priority starting just past the most recently served channel. sel drives
// the mux select; gnt is the matching one-hot enable.
//
// Optional feature: define RR_MUX_SELECT_TIMEOUT_EN to compile in the beat
// counter that force-releases a grant after MAX_BEATS cycles and pulses
// timeout. Without it the grant is held until done or req[sel] drops, and
// timeout is tied low.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no grant; arbitrate any pending request on the next edge
//   BUSY  | grant active on channel sel; wait for done / req drop / limit
module rr_mux_select #(
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,
  rr_mux_select_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Limit must leave at least one hold cycle and fit the beat counter.
  localparam bit CFG_OK = (MAX_BEATS >= 2) && (MAX_BEATS <= (2 ** CNT_W));

  if (!CFG_OK) begin : g_cfg_check
    $error("rr_mux_select: MAX_BEATS must be within 2..2**CNT_W");
  end

  logic [0:0] state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;

  logic [1:0] cand;
  logic [1:0] win;
  logic       win_found;
  logic       release_norm;
  logic       limit_hit;
  logic       release_any;

  // Rotating-priority search: first requester at or after last+1, wrapping.
  always_comb begin
    cand      = last_q;
    win       = last_q;
    win_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && bus.req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  // Ordinary release: consumer is finished or the owner withdrew its request.
  assign release_norm = bus.done | ~bus.req[sel_q];
  assign release_any  = release_norm | limit_hit;

  // Next-state logic for the grant FSM and its registered outputs.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_BUSY;
          sel_d   = win;
          gnt_d   = 4'b0001 << win;
          valid_d = 1'b1;
        end
      end
      ST_BUSY: begin
        // sel keeps its value across the release so the mux stays parked.
        if (release_any) begin
          state_d = ST_IDLE;
          last_d  = sel_q;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // FSM and output registers; last resets to 3 so channel 0 wins first.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;

`ifdef RR_MUX_SELECT_TIMEOUT_EN
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             timeout_q, timeout_d;
  logic             grant_start;
  logic             busy_hold;

  assign grant_start = (state_q == ST_IDLE) & win_found;
  assign busy_hold   = (state_q == ST_BUSY) & ~release_any;
  // Counter only advances while BUSY, so the compare is only meaningful there.
  assign limit_hit   = (state_q == ST_BUSY) & (beat_q == CNT_W'(MAX_BEATS - 1));

  // Beat counter and timeout pulse; an ordinary release masks the pulse.
  always_comb begin
    beat_d    = beat_q;
    timeout_d = 1'b0;
    if (grant_start) begin
      beat_d = '0;
    end else if (busy_hold) begin
      beat_d = beat_q + 1'b1;
    end else if (state_q == ST_BUSY) begin
      beat_d    = '0;
      timeout_d = limit_hit & ~release_norm;
    end
  end

  // Beat/timeout registers; reset clears any pending pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      beat_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign limit_hit   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_mux_select.sv
// tb_rr_mux_select: directed scenarios plus randomized traffic for
// rr_mux_select, every cycle compared against a behavioural model.
// Honours RR_MUX_SELECT_TIMEOUT_EN the same way the design does.
module tb_rr_mux_select;

  localparam int MAX_BEATS = 8;
  localparam int CNT_W     = 4;
`ifdef RR_MUX_SELECT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  rr_mux_select_if bus_if ();

  rr_mux_select #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int cyc_n;

  // reference model state
  bit m_busy;
  int m_last;
  int m_sel;
  int m_beats;
  bit m_to;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic model_step(input bit rst, input logic [3:0] rq, input bit dn);
    if (rst) begin
      m_busy = 0; m_last = 3; m_sel = 0; m_beats = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (rq[c]) begin
          m_busy = 1; m_sel = c; m_beats = 0;
          break;
        end
      end
    end else begin
      bit normal;
      bit lim;
      normal = dn || !rq[m_sel];
      lim    = TO_EN && (m_beats == MAX_BEATS - 1);
      if (normal || lim) begin
        m_busy = 0;
        m_last = m_sel;
        m_to   = lim && !normal;
      end else begin
        m_beats++;
        m_to = 0;
      end
    end
  endtask

  // one clock: drive, step the model, compare every output
  task automatic cyc(input bit rst, input logic [3:0] rq, input bit dn);
    reset = rst;
    bus_if.req  = rq;
    bus_if.done = dn;
    @(posedge clk);
    #1;
    cyc_n++;
    model_step(rst, rq, dn);
    check_val("sel", 32'(bus_if.sel), m_sel);
    check_val("gnt", 32'(bus_if.gnt), m_busy ? (1 << m_sel) : 0);
    check_val("valid", 32'(bus_if.valid), 32'(m_busy));
    check_val("timeout", 32'(bus_if.timeout), 32'(m_to));
  endtask

  initial begin
    int vcount;
    logic [3:0] rq;
    bit dn;
    bit rst;
    n_tests = 0; n_fail = 0; cyc_n = 0;
    clk = 0; reset = 1; bus_if.req = '0; bus_if.done = 0;

    // reset values
    cyc(1, 4'b0000, 0);
    cyc(1, 4'b1111, 1);
    check_val("rst_sel", 32'(bus_if.sel), 0);
    check_val("rst_gnt", 32'(bus_if.gnt), 0);
    check_val("rst_valid", 32'(bus_if.valid), 0);

    // single requester grant and done release
    cyc(0, 4'b0001, 0);
    check_val("t1_sel", 32'(bus_if.sel), 0);
    check_val("t1_gnt", 32'(bus_if.gnt), 32'h1);
    check_val("t1_valid", 32'(bus_if.valid), 1);
    cyc(0, 4'b0001, 1);
    check_val("t1_rel_valid", 32'(bus_if.valid), 0);
    check_val("t1_rel_gnt", 32'(bus_if.gnt), 0);

    // full rotation with one idle cycle between grants
    cyc(1, 4'b0000, 0);
    for (int g = 0; g < 5; g++) begin
      cyc(0, 4'b1111, 0);
      check_val("rr_sel", 32'(bus_if.sel), g % 4);
      check_val("rr_valid", 32'(bus_if.valid), 1);
      cyc(0, 4'b1111, 1);
      check_val("rr_gap", 32'(bus_if.valid), 0);
    end

    // wrap-around: last=1, req=0011 -> channel 0
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b0010, 0);
    check_val("wrap_first", 32'(bus_if.sel), 1);
    cyc(0, 4'b0010, 1);
    cyc(0, 4'b0011, 0);
    check_val("wrap_sel", 32'(bus_if.sel), 0);

    // held grant with no done
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b0100, 0);
    check_val("hold_sel", 32'(bus_if.sel), 2);
    vcount = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 4'b0100, 0);
      if (bus_if.valid) vcount++;
      else break;
    end
    if (TO_EN) begin
      check_val("to_beats", vcount, MAX_BEATS);
      check_val("to_pulse", 32'(bus_if.timeout), 1);
      cyc(0, 4'b0100, 0);
      check_val("to_pulse_end", 32'(bus_if.timeout), 0);
      check_val("to_regrant", 32'(bus_if.valid), 1);
      check_val("to_regrant_sel", 32'(bus_if.sel), 2);
    end else begin
      check_val("noto_held", vcount, 21);
      check_val("noto_timeout", 32'(bus_if.timeout), 0);
    end

    // done on the same cycle as the limit
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b0100, 0);
    repeat (MAX_BEATS - 1) cyc(0, 4'b0100, 0);
    cyc(0, 4'b0100, 1);
    check_val("dl_valid", 32'(bus_if.valid), 0);
    check_val("dl_timeout", 32'(bus_if.timeout), 0);

    // req[sel] drop releases
    cyc(0, 4'b0100, 0);
    cyc(0, 4'b0100, 0);
    check_val("drop_pre", 32'(bus_if.valid), 1);
    cyc(0, 4'b1011, 0);
    check_val("drop_valid", 32'(bus_if.valid), 0);

    // reset mid-BUSY with sel=2
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b0100, 0);
    cyc(0, 4'b0100, 0);
    check_val("mr_sel_pre", 32'(bus_if.sel), 2);
    cyc(1, 4'b0101, 0);
    check_val("mr_sel", 32'(bus_if.sel), 0);
    check_val("mr_valid", 32'(bus_if.valid), 0);
    check_val("mr_gnt", 32'(bus_if.gnt), 0);
    cyc(0, 4'b0101, 0);
    check_val("mr_first", 32'(bus_if.sel), 0);
    check_val("mr_first_valid", 32'(bus_if.valid), 1);

    // randomized traffic; requests are sticky so grants last a while
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      dn  = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 249) == 0);
      cyc(rst, rq, dn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
